// File: rtl/multi_push_propagation_queue.sv
// rtl/multi_push_propagation_queue.sv - multi-lane unit-propagation literal FIFO with duplicate/conflict filtering
//
// Purpose: accepts up to NUM_PUSH implied literals per cycle. A per-variable pending
// bitmap drops duplicates and flags opposite-polarity conflicts at enqueue time.
// The head literal is presented first-word-fall-through on a valid/ready pop port.
// Literal format: {var[VAR_WIDTH-1:0], sign}, where sign=1 means negated.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              synchronous clear of queue, bitmap and conflict (backtrack)
//   push_valid/lit     per-lane literal inputs, lane i at [i*LIT_WIDTH +: LIT_WIDTH]
//   push_ready         all lanes can be accepted this cycle
//   pop_valid/lit      head literal, pop_ready takes it
//   conflict           sticky flag; conflict_var holds the first conflicting variable
//   count/empty/full   occupancy status
//
// Optional macro PQ_STATS_EN adds stat_enq, stat_dup and stat_peak. These
// counters saturate and are cleared only by rst.
module multi_push_propagation_queue #(
    parameter int QUEUE_DEPTH = 32,
    parameter int VAR_WIDTH   = 5,
    parameter int NUM_PUSH    = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [NUM_PUSH-1:0]                 push_valid,
    input  logic [NUM_PUSH*(VAR_WIDTH+1)-1:0]   push_lit,
    output logic                                push_ready,
    output logic                                pop_valid,
    output logic [VAR_WIDTH:0]                  pop_lit,
    input  logic                                pop_ready,
    output logic                                conflict,
    output logic [VAR_WIDTH-1:0]                conflict_var,
    output logic [$clog2(QUEUE_DEPTH):0]        count,
    output logic                                empty,
    output logic                                full
`ifdef PQ_STATS_EN
    ,
    output logic [15:0]                         stat_enq,
    output logic [15:0]                         stat_dup,
    output logic [$clog2(QUEUE_DEPTH):0]        stat_peak
`endif
);

    localparam int NUM_VARS  = 2 ** VAR_WIDTH;
    localparam int LIT_WIDTH = VAR_WIDTH + 1;
    localparam int PW        = $clog2(QUEUE_DEPTH);
    localparam int CW        = PW + 1;

    logic [LIT_WIDTH-1:0] mem [QUEUE_DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [NUM_VARS-1:0]  pending;
    logic [NUM_VARS-1:0]  pend_sign;

    logic                 pop_fire;
    logic [VAR_WIDTH-1:0] head_var;
    logic [NUM_VARS-1:0]  eff_pend;
    logic [NUM_VARS-1:0]  eff_sign;
    logic [CW-1:0]        n_enq;
    logic [CW-1:0]        n_dup;
    logic [CW-1:0]        count_next;
    logic                 conf_found;
    logic [VAR_WIDTH-1:0] conf_var;
    logic [NUM_PUSH-1:0]  wr_en;
    logic [PW-1:0]        wr_idx [NUM_PUSH];
    logic [LIT_WIDTH-1:0] wr_lit [NUM_PUSH];
    logic [LIT_WIDTH-1:0] lane_lit;
    logic [VAR_WIDTH-1:0] lane_var;

    // Modulo-depth add. The offset never exceeds the depth, so one subtraction is enough.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [CW-1:0] k);
        logic [CW:0] s;
        s = (CW+1)'(base) + (CW+1)'(k);
        if (s >= (CW+1)'(QUEUE_DEPTH))
            s = s - (CW+1)'(QUEUE_DEPTH);
        return s[PW-1:0];
    endfunction

    assign pop_valid  = (count != '0);
    assign empty      = (count == '0);
    assign full       = (count == CW'(QUEUE_DEPTH));
    assign push_ready = !conflict && (count <= CW'(QUEUE_DEPTH - NUM_PUSH));
    assign pop_lit    = mem[head];
    assign head_var   = pop_lit[LIT_WIDTH-1:1];
    assign pop_fire   = pop_valid && pop_ready;

    // Resolve the lanes in order against a running copy of the bitmap. The copy
    // first drops the popped head, so a literal popped this cycle can be re-enqueued,
    // and it then picks up each literal accepted by a lower lane.
    always_comb begin
        eff_pend   = pending;
        eff_sign   = pend_sign;
        n_enq      = '0;
        n_dup      = '0;
        conf_found = 1'b0;
        conf_var   = '0;
        wr_en      = '0;
        lane_lit   = '0;
        lane_var   = '0;
        for (int i = 0; i < NUM_PUSH; i++) begin
            wr_idx[i] = '0;
            wr_lit[i] = '0;
        end
        if (pop_fire)
            eff_pend[head_var] = 1'b0;
        for (int i = 0; i < NUM_PUSH; i++) begin
            lane_lit  = push_lit[i*LIT_WIDTH +: LIT_WIDTH];
            lane_var  = lane_lit[LIT_WIDTH-1:1];
            wr_lit[i] = lane_lit;
            wr_idx[i] = wrap_add(tail, n_enq);
            if (push_valid[i] && push_ready) begin
                if (!eff_pend[lane_var]) begin
                    wr_en[i]           = 1'b1;
                    eff_pend[lane_var] = 1'b1;
                    eff_sign[lane_var] = lane_lit[0];
                    n_enq              = n_enq + CW'(1);
                end else if (eff_sign[lane_var] == lane_lit[0]) begin
                    n_dup = n_dup + CW'(1);
                end else if (!conf_found) begin
                    conf_found = 1'b1;
                    conf_var   = lane_var;
                end
            end
        end
        count_next = count + n_enq - {{(CW-1){1'b0}}, pop_fire};
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int i = 0; i < NUM_PUSH; i++)
                if (wr_en[i])
                    mem[wr_idx[i]] <= wr_lit[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            pending      <= '0;
            pend_sign    <= '0;
            conflict     <= 1'b0;
            conflict_var <= '0;
        end else begin
            if (pop_fire)
                head <= wrap_add(head, CW'(1));
            tail      <= wrap_add(tail, n_enq);
            count     <= count_next;
            pending   <= eff_pend;
            pend_sign <= eff_sign;
            if (conf_found) begin
                conflict <= 1'b1;
                if (!conflict)
                    conflict_var <= conf_var;
            end
        end
    end

`ifdef PQ_STATS_EN
    logic [16:0] enq_sum;
    logic [16:0] dup_sum;
    assign enq_sum = {1'b0, stat_enq} + 17'(n_enq);
    assign dup_sum = {1'b0, stat_dup} + 17'(n_dup);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_enq  <= '0;
            stat_dup  <= '0;
            stat_peak <= '0;
        end else if (!flush) begin
            stat_enq <= enq_sum[16] ? 16'hFFFF : enq_sum[15:0];
            stat_dup <= dup_sum[16] ? 16'hFFFF : dup_sum[15:0];
            if (count_next > stat_peak)
                stat_peak <= count_next;
        end
    end
`endif

endmodule

// File: tb/tb_multi_push_propagation_queue.sv
// tb/tb_multi_push_propagation_queue.sv - self-checking bench for multi_push_propagation_queue
module tb_multi_push_propagation_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  push_valid;
    logic [11:0] push_lit;
    logic        push_ready;
    logic        pop_valid;
    logic [5:0]  pop_lit;
    logic        pop_ready;
    logic        conflict;
    logic [4:0]  conflict_var;
    logic [5:0]  count;
    logic        empty;
    logic        full;

    logic        d4_flush;
    logic [1:0]  d4_push_valid;
    logic [11:0] d4_push_lit;
    logic        d4_push_ready;
    logic        d4_pop_valid;
    logic [5:0]  d4_pop_lit;
    logic        d4_pop_ready;
    logic        d4_conflict;
    logic [4:0]  d4_conflict_var;
    logic [2:0]  d4_count;
    logic        d4_empty;
    logic        d4_full;

`ifdef PQ_STATS_EN
    logic [15:0] stat_enq, stat_dup, d4_stat_enq, d4_stat_dup;
    logic [5:0]  stat_peak;
    logic [2:0]  d4_stat_peak;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_push_propagation_queue #(.QUEUE_DEPTH(32), .VAR_WIDTH(5), .NUM_PUSH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_valid(push_valid), .push_lit(push_lit), .push_ready(push_ready),
        .pop_valid(pop_valid), .pop_lit(pop_lit), .pop_ready(pop_ready),
        .conflict(conflict), .conflict_var(conflict_var),
        .count(count), .empty(empty), .full(full)
`ifdef PQ_STATS_EN
        , .stat_enq(stat_enq), .stat_dup(stat_dup), .stat_peak(stat_peak)
`endif
    );

    multi_push_propagation_queue #(.QUEUE_DEPTH(4), .VAR_WIDTH(5), .NUM_PUSH(2)) d4 (
        .clk(clk), .rst(rst), .flush(d4_flush),
        .push_valid(d4_push_valid), .push_lit(d4_push_lit), .push_ready(d4_push_ready),
        .pop_valid(d4_pop_valid), .pop_lit(d4_pop_lit), .pop_ready(d4_pop_ready),
        .conflict(d4_conflict), .conflict_var(d4_conflict_var),
        .count(d4_count), .empty(d4_empty), .full(d4_full)
`ifdef PQ_STATS_EN
        , .stat_enq(d4_stat_enq), .stat_dup(d4_stat_dup), .stat_peak(d4_stat_peak)
`endif
    );

    typedef struct {
        logic       flush;
        logic [1:0] pv;
        logic [5:0] lit1;
        logic [5:0] lit0;
        logic       pr;
        int         e_count;
        logic       e_pv;
        logic [5:0] e_lit;
        logic       e_prdy;
        logic       e_conf;
        logic [4:0] e_cvar;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d4_pop_check(input string name, input logic [5:0] exp_lit);
        chk({name, "_pv"}, int'(d4_pop_valid), 1);
        chk({name, "_lit"}, int'(d4_pop_lit), int'(exp_lit));
        d4_pop_ready = 1'b1;
        tick();
        d4_pop_ready = 1'b0;
    endtask

    initial begin
        //            fl pv     lit1   lit0   pr cnt pv lit    rdy cf cvar
        vecs[0]  = '{0, 2'b01, 6'h00, 6'h0A, 0, 1, 1, 6'h0A, 1, 0, 5'd0};
        vecs[1]  = '{0, 2'b00, 6'h00, 6'h00, 1, 0, 0, 6'h00, 1, 0, 5'd0};
        vecs[2]  = '{0, 2'b11, 6'h0A, 6'h0A, 0, 1, 1, 6'h0A, 1, 0, 5'd0};
        vecs[3]  = '{0, 2'b00, 6'h00, 6'h00, 1, 0, 0, 6'h00, 1, 0, 5'd0};
        vecs[4]  = '{0, 2'b01, 6'h00, 6'h0A, 0, 1, 1, 6'h0A, 1, 0, 5'd0};
        vecs[5]  = '{0, 2'b01, 6'h00, 6'h0B, 0, 1, 1, 6'h0A, 0, 1, 5'd5};
        vecs[6]  = '{1, 2'b01, 6'h00, 6'h04, 1, 0, 0, 6'h00, 1, 0, 5'd0};
        vecs[7]  = '{0, 2'b01, 6'h00, 6'h0A, 0, 1, 1, 6'h0A, 1, 0, 5'd0};
        vecs[8]  = '{0, 2'b01, 6'h00, 6'h0A, 1, 1, 1, 6'h0A, 1, 0, 5'd0};
        vecs[9]  = '{0, 2'b00, 6'h00, 6'h00, 1, 0, 0, 6'h00, 1, 0, 5'd0};
        vecs[10] = '{0, 2'b11, 6'h07, 6'h04, 0, 2, 1, 6'h04, 1, 0, 5'd0};
        vecs[11] = '{0, 2'b11, 6'h08, 6'h05, 0, 3, 1, 6'h04, 0, 1, 5'd2};
        vecs[12] = '{0, 2'b11, 6'h0C, 6'h0E, 1, 2, 1, 6'h07, 0, 1, 5'd2};
        vecs[13] = '{0, 2'b00, 6'h00, 6'h00, 1, 1, 1, 6'h08, 0, 1, 5'd2};
        vecs[14] = '{0, 2'b00, 6'h00, 6'h00, 1, 0, 0, 6'h00, 0, 1, 5'd2};
        vecs[15] = '{1, 2'b00, 6'h00, 6'h00, 0, 0, 0, 6'h00, 1, 0, 5'd0};
        vecs[16] = '{0, 2'b11, 6'h08, 6'h06, 0, 2, 1, 6'h06, 1, 0, 5'd0};
        vecs[17] = '{0, 2'b11, 6'h07, 6'h09, 0, 2, 1, 6'h06, 0, 1, 5'd4};
        vecs[18] = '{1, 2'b00, 6'h00, 6'h00, 0, 0, 0, 6'h00, 1, 0, 5'd0};
        vecs[19] = '{0, 2'b11, 6'h0B, 6'h0A, 0, 1, 1, 6'h0A, 0, 1, 5'd5};
        vecs[20] = '{1, 2'b00, 6'h00, 6'h00, 0, 0, 0, 6'h00, 1, 0, 5'd0};

        rst = 1'b1; flush = 1'b0; push_valid = '0; push_lit = '0; pop_ready = 1'b0;
        d4_flush = 1'b0; d4_push_valid = '0; d4_push_lit = '0; d4_pop_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("reset_count", int'(count), 0);
        chk("reset_empty", int'(empty), 1);
        chk("reset_full", int'(full), 0);
        chk("reset_pop_valid", int'(pop_valid), 0);
        chk("reset_push_ready", int'(push_ready), 1);
        chk("reset_conflict", int'(conflict), 0);

        for (int v = 0; v < NV; v++) begin
            flush      = vecs[v].flush;
            push_valid = vecs[v].pv;
            push_lit   = {vecs[v].lit1, vecs[v].lit0};
            pop_ready  = vecs[v].pr;
            tick();
            flush = 1'b0; push_valid = '0; pop_ready = 1'b0;
            chk($sformatf("v%0d_count", v), int'(count), vecs[v].e_count);
            chk($sformatf("v%0d_pop_valid", v), int'(pop_valid), int'(vecs[v].e_pv));
            if (vecs[v].e_pv)
                chk($sformatf("v%0d_pop_lit", v), int'(pop_lit), int'(vecs[v].e_lit));
            chk($sformatf("v%0d_push_ready", v), int'(push_ready), int'(vecs[v].e_prdy));
            chk($sformatf("v%0d_conflict", v), int'(conflict), int'(vecs[v].e_conf));
            chk($sformatf("v%0d_conflict_var", v), int'(conflict_var), int'(vecs[v].e_cvar));
            chk($sformatf("v%0d_empty", v), int'(empty), int'(vecs[v].e_count == 0));
        end

`ifdef PQ_STATS_EN
        chk("stat_enq", int'(stat_enq), 11);
        chk("stat_dup", int'(stat_dup), 1);
        chk("stat_peak", int'(stat_peak), 3);
`endif

        // Reset with pushes and pops pending must win and discard them.
        push_valid = 2'b11; push_lit = {6'h02, 6'h04}; tick();
        push_valid = 2'b01; push_lit = {6'h00, 6'h06}; tick();
        chk("pre_rst_count", int'(count), 3);
        rst = 1'b1; push_valid = 2'b11; push_lit = {6'h0C, 6'h0E}; pop_ready = 1'b1;
        tick();
        rst = 1'b0; push_valid = '0; pop_ready = 1'b0;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_conflict", int'(conflict), 0);
`ifdef PQ_STATS_EN
        chk("rst_stat_enq", int'(stat_enq), 0);
`endif

        // Depth-4 instance: push_ready gating and pointer wrap.
        d4_push_valid = 2'b11; d4_push_lit = {6'h04, 6'h02}; tick();
        d4_push_valid = '0;
        chk("d4_count2", int'(d4_count), 2);
        chk("d4_ready2", int'(d4_push_ready), 1);
        d4_push_valid = 2'b01; d4_push_lit = {6'h00, 6'h06}; tick();
        d4_push_valid = '0;
        chk("d4_count3", int'(d4_count), 3);
        chk("d4_ready3", int'(d4_push_ready), 0);
        d4_pop_check("d4_pop0", 6'h02);
        chk("d4_ready_after_pop", int'(d4_push_ready), 1);
        chk("d4_count_after_pop", int'(d4_count), 2);
        chk("d4_head", int'(d4_pop_lit), 6'h04);
        d4_push_valid = 2'b11; d4_push_lit = {6'h0A, 6'h08}; d4_pop_ready = 1'b1;
        tick();
        d4_push_valid = '0; d4_pop_ready = 1'b0;
        chk("d4_wrap_count", int'(d4_count), 3);
        chk("d4_wrap_ready", int'(d4_push_ready), 0);
        d4_pop_check("d4_pop2", 6'h06);
        d4_pop_check("d4_pop3", 6'h08);
        d4_pop_check("d4_pop4", 6'h0A);
        chk("d4_empty", int'(d4_empty), 1);
        d4_push_valid = 2'b11; d4_push_lit = {6'h0C, 6'h02}; tick();
        d4_push_valid = '0;
        chk("d4_count_again", int'(d4_count), 2);
        d4_pop_check("d4_pop5", 6'h02);
        d4_pop_check("d4_pop6", 6'h0C);
        chk("d4_final_empty", int'(d4_empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
